// File: rtl/bcd_digit_converter.sv
// Sequential binary-to-BCD converter (shift-and-add-3) feeding the per-digit 7-segment decoders.
// Latency: done pulses BIN_W edges after the edge that accepts start (one shift per cycle).
// Backpressure: start is ignored while busy (no queueing); a start during the done cycle chains directly.
//
// Ports:
//   clk       in   system clock, rising edge
//   rst_n     in   asynchronous active-low reset, clears every output and the FSM
//   start     in   conversion request, accepted when busy is low
//   bin_in    in   BIN_W-bit unsigned value, captured on the accepting edge
//   busy      out  high while shifting
//   done      out  one-cycle pulse when digits/blank/overflow have just been updated
//   digits    out  4*DIGITS BCD result, digit k at [4k+3:4k], k=0 least significant
//   blank     out  DIGITS leading-zero flags (digit 0 never flagged)
//   overflow  out  value did not fit in DIGITS decimal digits; digits then read all 9s
module bcd_digit_converter #(
  parameter int BIN_W    = 8,
  parameter int DIGITS   = 3,
  parameter bit BLANK_LZ = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [BIN_W-1:0]      bin_in,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   digits,
  output logic [DIGITS-1:0]     blank,
  output logic                  overflow
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(BIN_W + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t             state_q, state_d;

  // Working registers of the conversion.
  logic [BCD_W-1:0]   bcd_q, bcd_d;
  logic [BIN_W-1:0]   sr_q, sr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ovf_acc_q, ovf_acc_d;

  // Held display outputs; only touched on completion.
  logic [BCD_W-1:0]   digits_q, digits_d;
  logic [DIGITS-1:0]  blank_q, blank_d;
  logic               overflow_q, overflow_d;

  logic               accept;
  logic               last_shift;
  logic [BCD_W-1:0]   adj_bcd;
  logic [BCD_W+BIN_W:0] step_w;
  logic               step_out;
  logic [BCD_W-1:0]   step_bcd;
  logic [BIN_W-1:0]   step_sr;
  logic               ovf_final;
  logic [DIGITS-1:0]  lz_flags;

  // A new request is taken in IDLE and also in DONE, which gives back-to-back conversions.
  assign accept     = start && (state_q != S_SHIFT);
  assign last_shift = (cnt_q == CNT_W'(BIN_W - 1));

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next state
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_SHIFT;
      S_SHIFT: if (last_shift) state_d = S_DONE;
      S_DONE:  state_d = start ? S_SHIFT : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: outputs (decoded purely from state, no path from inputs)
  // --------------------------------------------------------------------------
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state_q)
      S_SHIFT: busy = 1'b1;
      S_DONE:  done = 1'b1;
      default: begin
        busy = 1'b0;
        done = 1'b0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // One double-dabble step: add 3 to every digit >= 5, then shift {bcd, sr}
  // left by one. The bit leaving the top digit is the overflow indicator.
  // --------------------------------------------------------------------------
  always_comb begin
    adj_bcd = bcd_q;
    for (int k = 0; k < DIGITS; k++) begin
      if (bcd_q[4*k +: 4] >= 4'd5) begin
        adj_bcd[4*k +: 4] = bcd_q[4*k +: 4] + 4'd3;
      end
    end
  end

  // Extra zero at the bottom keeps this valid for BIN_W = 1.
  assign step_w    = {adj_bcd, sr_q, 1'b0};
  assign step_out  = step_w[BCD_W+BIN_W];
  assign step_bcd  = step_w[BCD_W+BIN_W-1:BIN_W];
  assign step_sr   = step_w[BIN_W-1:0];
  assign ovf_final = ovf_acc_q | step_out;

  // Leading-zero flags of the final result: scan from the top digit down,
  // staying set while every digit seen so far is zero. Digit 0 is excluded.
  always_comb begin
    logic run_zero;
    lz_flags = '0;
    run_zero = 1'b1;
    if (BLANK_LZ) begin
      for (int k = DIGITS - 1; k > 0; k--) begin
        run_zero    = run_zero & (step_bcd[4*k +: 4] == 4'd0);
        lz_flags[k] = run_zero;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Datapath next state
  // --------------------------------------------------------------------------
  always_comb begin
    bcd_d      = bcd_q;
    sr_d       = sr_q;
    cnt_d      = cnt_q;
    ovf_acc_d  = ovf_acc_q;
    digits_d   = digits_q;
    blank_d    = blank_q;
    overflow_d = overflow_q;

    if (accept) begin
      bcd_d     = '0;
      sr_d      = bin_in;
      cnt_d     = '0;
      ovf_acc_d = 1'b0;
    end else if (state_q == S_SHIFT) begin
      bcd_d     = step_bcd;
      sr_d      = step_sr;
      cnt_d     = cnt_q + CNT_W'(1);
      ovf_acc_d = ovf_final;
      if (last_shift) begin
        if (ovf_final) begin
          // Saturate so the display never shows a truncated value.
          digits_d   = {DIGITS{4'h9}};
          blank_d    = '0;
          overflow_d = 1'b1;
        end else begin
          digits_d   = step_bcd;
          blank_d    = lz_flags;
          overflow_d = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bcd_q      <= '0;
      sr_q       <= '0;
      cnt_q      <= '0;
      ovf_acc_q  <= 1'b0;
      digits_q   <= '0;
      blank_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      bcd_q      <= bcd_d;
      sr_q       <= sr_d;
      cnt_q      <= cnt_d;
      ovf_acc_q  <= ovf_acc_d;
      digits_q   <= digits_d;
      blank_q    <= blank_d;
      overflow_q <= overflow_d;
    end
  end

  assign digits   = digits_q;
  assign blank    = blank_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_bcd_digit_converter.sv
// Directed bench: two converters (3-digit and 2-digit) share start/bin_in and run in lockstep.
// Edge numbering: the edge that samples start is edge 1; done is expected after edge 9.
// Every expected value below is hand-computed decimal-to-BCD.
module tb_bcd_digit_converter;

  logic        clk    = 1'b0;
  logic        rst_n  = 1'b0;
  logic        start  = 1'b0;
  logic [7:0]  bin_in = 8'd0;

  logic        busy3, done3, ovf3;
  logic [11:0] dig3;
  logic [2:0]  blk3;
  logic        busy2, done2, ovf2;
  logic [7:0]  dig2;
  logic [1:0]  blk2;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  bcd_digit_converter #(.BIN_W(8), .DIGITS(3), .BLANK_LZ(1'b1)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .start(start), .bin_in(bin_in),
    .busy(busy3), .done(done3), .digits(dig3), .blank(blk3), .overflow(ovf3)
  );

  bcd_digit_converter #(.BIN_W(8), .DIGITS(2), .BLANK_LZ(1'b1)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .start(start), .bin_in(bin_in),
    .busy(busy2), .done(done2), .digits(dig2), .blank(blk2), .overflow(ovf2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Requests a conversion of v, waits (bounded) for done and checks both results.
  // Returns while done is high so the caller can chain another request.
  task automatic convert(input logic [7:0] v,
                         input logic [11:0] e3d, input logic [2:0] e3b,
                         input logic [7:0] e2d, input logic [1:0] e2b, input logic e2o);
    int edges;
    start  = 1'b1;
    bin_in = v;
    tick;
    start  = 1'b0;
    bin_in = ~v;              // must not disturb the captured value
    edges  = 1;
    check($sformatf("busy_after_accept_%0d", v), busy3, 1);
    while (!done3 && edges < 30) begin
      tick;
      edges++;
    end
    check($sformatf("latency_%0d", v), edges, 9);
    check($sformatf("done2_%0d", v), done2, 1);
    check($sformatf("busy_at_done_%0d", v), busy3, 0);
    check($sformatf("dig3_%0d", v), dig3, e3d);
    check($sformatf("blk3_%0d", v), blk3, e3b);
    check($sformatf("ovf3_%0d", v), ovf3, 0);
    check($sformatf("dig2_%0d", v), dig2, e2d);
    check($sformatf("blk2_%0d", v), blk2, e2b);
    check($sformatf("ovf2_%0d", v), ovf2, e2o);
  endtask

  task automatic finish_done(input logic [11:0] e3d);
    tick;
    check("done_single_cycle", done3, 0);
    check("done2_single_cycle", done2, 0);
    check("idle_not_busy", busy3, 0);
    check("digits_held", dig3, e3d);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ndone;

    // Reset state
    #12;
    check("rst_busy", busy3, 0);
    check("rst_done", done3, 0);
    check("rst_digits", dig3, 0);
    check("rst_blank", blk3, 0);
    check("rst_ovf", ovf3, 0);
    check("rst_ovf2", ovf2, 0);
    @(negedge clk);
    rst_n = 1'b1;

    //       value  dig3     blk3    dig2   blk2   ovf2
    convert(8'd0,   12'h000, 3'b110, 8'h00, 2'b10, 1'b0); finish_done(12'h000);
    convert(8'd255, 12'h255, 3'b000, 8'h99, 2'b00, 1'b1); finish_done(12'h255);
    convert(8'd7,   12'h007, 3'b110, 8'h07, 2'b10, 1'b0); finish_done(12'h007);
    convert(8'd42,  12'h042, 3'b100, 8'h42, 2'b00, 1'b0); finish_done(12'h042);
    convert(8'd200, 12'h200, 3'b000, 8'h99, 2'b00, 1'b1); finish_done(12'h200);
    convert(8'd99,  12'h099, 3'b100, 8'h99, 2'b00, 1'b0); finish_done(12'h099);
    convert(8'd100, 12'h100, 3'b000, 8'h99, 2'b00, 1'b1); finish_done(12'h100);
    convert(8'd10,  12'h010, 3'b100, 8'h10, 2'b00, 1'b0); finish_done(12'h010);

    // Start pulsed while busy is ignored: conversion of 130, extra request during cycle 3.
    start  = 1'b1;
    bin_in = 8'd130;
    tick;                     // edge 1 accepts 130
    start  = 1'b0;
    tick;
    tick;
    start  = 1'b1;
    bin_in = 8'd42;
    tick;
    start  = 1'b0;
    check("busy_ignores_start", busy3, 1);
    check("no_partial_digits", dig3, 12'h010);
    ndone = 0;
    for (int i = 0; i < 20; i++) begin
      tick;
      if (done3) ndone++;
    end
    check("single_done", ndone, 1);
    check("dig3_130", dig3, 12'h130);
    check("blk3_130", blk3, 3'b000);
    check("dig2_130", dig2, 8'h99);
    check("ovf2_130", ovf2, 1);

    // Back-to-back: convert 130 again, then request 17 on the DONE cycle.
    convert(8'd130, 12'h130, 3'b000, 8'h99, 2'b00, 1'b1);
    convert(8'd17,  12'h017, 3'b100, 8'h17, 2'b00, 1'b0);
    finish_done(12'h017);

    // Reset asserted at cycle 4 of a conversion: abort, clear, no done afterwards.
    start  = 1'b1;
    bin_in = 8'd200;
    tick;
    start  = 1'b0;
    tick;
    tick;
    tick;
    check("hold_mid_conversion", dig3, 12'h017);
    check("busy_mid_conversion", busy3, 1);
    rst_n = 1'b0;
    #1;
    check("abort_busy", busy3, 0);
    check("abort_done", done3, 0);
    check("abort_digits", dig3, 0);
    check("abort_blank", blk3, 0);
    check("abort_digits2", dig2, 0);
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    for (int i = 0; i < 20; i++) begin
      tick;
      if (done3 || done2 || busy3) ndone++;
    end
    check("quiet_after_abort", ndone, 0);

    // Recovery after the aborted conversion.
    convert(8'd5, 12'h005, 3'b110, 8'h05, 2'b10, 1'b0);
    finish_done(12'h005);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
